// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared opcodes, funct codes, state/kind/ALU enums and immediate generator for riscv_multi_core
package riscv_pkg;

  localparam logic [31:0] EOF_DEFAULT = 32'hFFFF_FFFF;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_W    = 3'b010;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_JALR = 3'b000;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;
  localparam logic [6:0] F7_MUL  = 7'b0000001;

  typedef enum logic [2:0] {S_IF, S_ID, S_EX, S_MEM, S_WB, S_HALT} state_e;
  typedef enum logic [2:0] {K_ALU, K_LOAD, K_STORE, K_BRANCH, K_JAL, K_JALR} kind_e;
  typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_SLT, ALU_MUL} alu_op_e;
  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_fmt_e;

  // Sign-extended immediate for each RV32 instruction format.
  function automatic logic [31:0] imm_gen(input logic [31:0] ir, input imm_fmt_e fmt);
    case (fmt)
      IMM_S:   imm_gen = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      IMM_B:   imm_gen = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      IMM_U:   imm_gen = {ir[31:12], 12'h000};
      IMM_J:   imm_gen = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
      default: imm_gen = {{20{ir[31]}}, ir[31:20]};
    endcase
  endfunction

endpackage

// File: rtl/riscv_alu.sv
// rtl/riscv_alu.sv - combinational ALU with branch flags; multiplier present only with RISCV_MUL_EN
// Ports: i_op (operation), i_a/i_b (operands) -> o_result, o_lt (signed a<b), o_eq (a==b),
//        o_bad (operation not available in this build).
// Macro RISCV_MUL_EN: when defined ALU_MUL returns the low 32 bits of a*b; otherwise it raises o_bad.
module riscv_alu
  import riscv_pkg::*;
(
  input  alu_op_e     i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_result,
  output logic        o_lt,
  output logic        o_eq,
  output logic        o_bad
);

  assign o_lt = $signed(i_a) < $signed(i_b);
  assign o_eq = (i_a == i_b);

  always_comb begin
    o_bad    = 1'b0;
    o_result = i_a + i_b;
    case (i_op)
      ALU_ADD: o_result = i_a + i_b;
      ALU_SUB: o_result = i_a - i_b;
      ALU_SLT: o_result = {31'b0, o_lt};
      ALU_MUL: begin
`ifdef RISCV_MUL_EN
        o_result = i_a * i_b;
`else
        o_result = '0;
        o_bad    = 1'b1;
`endif
      end
      default: o_result = i_a + i_b;
    endcase
  end

endmodule

// File: rtl/riscv_multi_core.sv
// rtl/riscv_multi_core.sv - multicycle RV32 integer-subset core with req/ack instruction and data ports
// Ports: CLOCK_50, rst (async active-low); imem_req/addr/ack/rdata fetch port; dmem_req/we/addr/wdata/ack/rdata
//        data port; done (EOF retired), err (illegal instruction), clock_count, instr_cnt.
// Macro RISCV_MUL_EN (in riscv_alu): enables the mul instruction; without it mul halts with err.
module riscv_multi_core
  import riscv_pkg::*;
#(
  parameter int unsigned IMEM_AW  = 6,
  parameter int unsigned DMEM_AW  = 13,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] EOF_WORD = EOF_DEFAULT
) (
  input  logic               CLOCK_50,
  input  logic               rst,
  output logic               imem_req,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic               imem_ack,
  input  logic [31:0]        imem_rdata,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [DMEM_AW-1:0] dmem_addr,
  output logic [31:0]        dmem_wdata,
  input  logic               dmem_ack,
  input  logic [31:0]        dmem_rdata,
  output logic               done,
  output logic               err,
  output logic [31:0]        clock_count,
  output logic [31:0]        instr_cnt
);

  state_e       r_state;
  kind_e        r_kind;
  alu_op_e      r_alu_op;
  logic [31:0]  r_pc, r_ir, r_a, r_b, r_rs2, r_target, r_alu_out, r_mdr;
  logic [4:0]   r_rd;
  logic [2:0]   r_funct3;
  logic         r_done, r_err, r_dmem_we;
  logic [DMEM_AW-1:0] r_dmem_addr;
  logic [31:0]  r_dmem_wdata, r_clock_count, r_instr_cnt;
  logic [31:0]  r_regs [32];

  logic [6:0]   w_opcode, w_funct7;
  logic [2:0]   w_funct3;
  logic [31:0]  w_rs1_val, w_rs2_val, w_imm, w_opa, w_opb;
  logic [31:0]  w_alu_result, w_wb_data, w_next_pc, w_pc_plus4;
  logic         w_legal, w_alu_lt, w_alu_eq, w_alu_bad, w_taken, w_halting;
  kind_e        w_kind;
  alu_op_e      w_alu_op;
  imm_fmt_e     w_fmt;

  // Requests follow the state register directly so a zero-wait memory can ack in the
  // entry cycle; gating with rst keeps them low while reset is held.
  assign imem_req    = (r_state == S_IF)  & rst;
  assign dmem_req    = (r_state == S_MEM) & rst;
  assign imem_addr   = r_pc[IMEM_AW+1:2];
  assign dmem_we     = r_dmem_we;
  assign dmem_addr   = r_dmem_addr;
  assign dmem_wdata  = r_dmem_wdata;
  assign done        = r_done;
  assign err         = r_err;
  assign clock_count = r_clock_count;
  assign instr_cnt   = r_instr_cnt;

  assign w_opcode   = r_ir[6:0];
  assign w_funct3   = r_ir[14:12];
  assign w_funct7   = r_ir[31:25];
  assign w_rs1_val  = (r_ir[19:15] == 5'd0) ? 32'h0 : r_regs[r_ir[19:15]];
  assign w_rs2_val  = (r_ir[24:20] == 5'd0) ? 32'h0 : r_regs[r_ir[24:20]];
  assign w_imm      = imm_gen(r_ir, w_fmt);
  assign w_pc_plus4 = r_pc + 32'd4;

  // Decode: instruction kind, ALU op, immediate format and operand selection.
  always_comb begin
    w_legal  = 1'b1;
    w_kind   = K_ALU;
    w_alu_op = ALU_ADD;
    w_fmt    = IMM_I;
    w_opa    = w_rs1_val;
    w_opb    = w_imm;
    case (w_opcode)
      OP_R: begin
        w_opb = w_rs2_val;
        if (w_funct3 == F3_ADD && w_funct7 == F7_BASE)     w_alu_op = ALU_ADD;
        else if (w_funct3 == F3_ADD && w_funct7 == F7_SUB) w_alu_op = ALU_SUB;
        else if (w_funct3 == F3_ADD && w_funct7 == F7_MUL) w_alu_op = ALU_MUL;
        else                                               w_legal  = 1'b0;
      end
      OP_IMM: begin
        if (w_funct3 == F3_ADD)      w_alu_op = ALU_ADD;
        else if (w_funct3 == F3_SLT) w_alu_op = ALU_SLT;
        else                         w_legal  = 1'b0;
      end
      OP_LOAD: begin
        w_kind  = K_LOAD;
        w_legal = (w_funct3 == F3_W);
      end
      OP_STORE: begin
        w_kind  = K_STORE;
        w_fmt   = IMM_S;
        w_legal = (w_funct3 == F3_W);
      end
      OP_BRANCH: begin
        w_kind   = K_BRANCH;
        w_fmt    = IMM_B;
        w_alu_op = ALU_SUB;
        w_opb    = w_rs2_val;
        w_legal  = (w_funct3 == F3_BEQ) || (w_funct3 == F3_BNE) ||
                   (w_funct3 == F3_BLT) || (w_funct3 == F3_BGE);
      end
      OP_LUI: begin
        w_fmt = IMM_U;
        w_opa = 32'h0;
      end
      OP_AUIPC: begin
        w_fmt = IMM_U;
        w_opa = r_pc;
      end
      OP_JAL: begin
        w_kind = K_JAL;
        w_fmt  = IMM_J;
      end
      OP_JALR: begin
        w_kind  = K_JALR;
        w_legal = (w_funct3 == F3_JALR);
      end
      default: w_legal = 1'b0;
    endcase
  end

  riscv_alu u_alu (
    .i_op     (r_alu_op),
    .i_a      (r_a),
    .i_b      (r_b),
    .o_result (w_alu_result),
    .o_lt     (w_alu_lt),
    .o_eq     (w_alu_eq),
    .o_bad    (w_alu_bad)
  );

  always_comb begin
    case (r_funct3)
      F3_BEQ:  w_taken = w_alu_eq;
      F3_BNE:  w_taken = !w_alu_eq;
      F3_BLT:  w_taken = w_alu_lt;
      F3_BGE:  w_taken = !w_alu_lt;
      default: w_taken = 1'b0;
    endcase
  end

  assign w_wb_data = (r_kind == K_LOAD) ? r_mdr :
                     (r_kind == K_JAL || r_kind == K_JALR) ? w_pc_plus4 : r_alu_out;
  assign w_next_pc = (r_kind == K_JAL)  ? r_target :
                     (r_kind == K_JALR) ? (r_alu_out & ~32'h1) : w_pc_plus4;

  // The decision cycle that leads into HALT is treated as part of the halt.
  assign w_halting = (r_state == S_ID && (r_ir == EOF_WORD || !w_legal)) ||
                     (r_state == S_EX && w_alu_bad);

  always_ff @(posedge CLOCK_50 or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IF;
      r_kind       <= K_ALU;
      r_alu_op     <= ALU_ADD;
      r_pc         <= RESET_PC;
      r_ir         <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_rs2        <= '0;
      r_target     <= '0;
      r_alu_out    <= '0;
      r_mdr        <= '0;
      r_rd         <= '0;
      r_funct3     <= '0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_dmem_we    <= 1'b0;
      r_dmem_addr  <= '0;
      r_dmem_wdata <= '0;
      r_instr_cnt  <= '0;
      for (int i = 0; i < 32; i++) r_regs[i] <= '0;
    end else begin
      case (r_state)
        S_IF: begin
          if (imem_ack) begin
            r_ir    <= imem_rdata;
            r_state <= S_ID;
          end
        end
        S_ID: begin
          if (r_ir == EOF_WORD) begin
            r_done  <= 1'b1;
            r_state <= S_HALT;
          end else if (!w_legal) begin
            r_err   <= 1'b1;
            r_state <= S_HALT;
          end else begin
            r_kind   <= w_kind;
            r_alu_op <= w_alu_op;
            r_a      <= w_opa;
            r_b      <= w_opb;
            r_rs2    <= w_rs2_val;
            r_target <= r_pc + w_imm;
            r_rd     <= r_ir[11:7];
            r_funct3 <= w_funct3;
            r_state  <= S_EX;
          end
        end
        S_EX: begin
          if (w_alu_bad) begin
            r_err   <= 1'b1;
            r_state <= S_HALT;
          end else begin
            r_alu_out <= w_alu_result;
            case (r_kind)
              K_BRANCH: begin
                r_pc        <= w_taken ? r_target : w_pc_plus4;
                r_instr_cnt <= r_instr_cnt + 32'd1;
                r_state     <= S_IF;
              end
              K_LOAD, K_STORE: begin
                r_dmem_addr  <= w_alu_result[DMEM_AW+1:2];
                r_dmem_we    <= (r_kind == K_STORE);
                r_dmem_wdata <= r_rs2;
                r_state      <= S_MEM;
              end
              default: r_state <= S_WB;
            endcase
          end
        end
        S_MEM: begin
          if (dmem_ack) begin
            if (r_dmem_we) begin
              r_pc        <= w_pc_plus4;
              r_instr_cnt <= r_instr_cnt + 32'd1;
              r_state     <= S_IF;
            end else begin
              r_mdr   <= dmem_rdata;
              r_state <= S_WB;
            end
          end
        end
        S_WB: begin
          if (r_rd != 5'd0) r_regs[r_rd] <= w_wb_data;
          r_pc        <= w_next_pc;
          r_instr_cnt <= r_instr_cnt + 32'd1;
          r_state     <= S_IF;
        end
        default: r_state <= S_HALT;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or negedge rst) begin
    if (!rst) begin
      r_clock_count <= '0;
    end else if (r_state != S_HALT && !w_halting) begin
      r_clock_count <= r_clock_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_riscv_multi_core.sv
// tb/tb_riscv_multi_core.sv - directed self-checking bench for riscv_multi_core
module tb_riscv_multi_core;

  logic        clk;
  logic        rst;
  logic        imem_req, imem_ack;
  logic [5:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [12:0] dmem_addr;
  logic [31:0] dmem_wdata, dmem_rdata;
  logic        done, err;
  logic [31:0] clock_count, instr_cnt;

  logic [31:0] imem [64];
  logic [31:0] dmem [256];
  int          d_wait;
  int          d_cnt;
  int          n_acc;
  logic [12:0] acc_addr   [16];
  logic [31:0] acc_wdata  [16];
  logic        acc_we     [16];
  int          acc_cycles [16];

  int n_total;
  int n_bad;

  riscv_multi_core dut (
    .CLOCK_50    (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_addr   (dmem_addr),
    .dmem_wdata  (dmem_wdata),
    .dmem_ack    (dmem_ack),
    .dmem_rdata  (dmem_rdata),
    .done        (done),
    .err         (err),
    .clock_count (clock_count),
    .instr_cnt   (instr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory models: imem is zero-wait, dmem acks in the (d_wait+1)-th cycle of a request.
  always @(negedge clk) begin
    imem_ack   = imem_req;
    imem_rdata = imem[imem_addr];
    if (dmem_req) begin
      d_cnt = d_cnt + 1;
      if (d_cnt > d_wait) begin
        dmem_ack   = 1'b1;
        dmem_rdata = dmem[dmem_addr[7:0]];
        if (dmem_we) dmem[dmem_addr[7:0]] = dmem_wdata;
        if (n_acc < 16) begin
          acc_addr[n_acc]   = dmem_addr;
          acc_wdata[n_acc]  = dmem_wdata;
          acc_we[n_acc]     = dmem_we;
          acc_cycles[n_acc] = d_cnt;
          n_acc = n_acc + 1;
        end
      end else begin
        dmem_ack = 1'b0;
      end
    end else begin
      d_cnt    = 0;
      dmem_ack = 1'b0;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total = n_total + 1;
    if (got !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    enc_r = {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] op);
    enc_i = {imm[11:0], rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
    enc_s = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3);
    enc_b = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd, input logic [6:0] op);
    enc_u = {imm, rd, op};
  endfunction

  function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [4:0] rd);
    enc_j = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  task automatic clear_prog();
    for (int i = 0; i < 64; i++) imem[i] = 32'hFFFF_FFFF;
  endtask

  task automatic start_core();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic run_prog(input string tag);
    int c;
    start_core();
    c = 0;
    while (c < 2000 && !(done || err)) begin
      @(negedge clk);
      c++;
    end
    check_eq({tag, "_finished"}, {31'b0, done | err}, 32'd1);
  endtask

  localparam logic [6:0] OPI = 7'b0010011;

  initial begin
    n_total = 0;
    n_bad   = 0;
    d_wait  = 0;
    d_cnt   = 0;
    n_acc   = 0;
    rst     = 1'b0;
    for (int i = 0; i < 256; i++) dmem[i] = 32'h0;
    clear_prog();

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_done",  {31'b0, done}, 32'd0);
    check_eq("rst_err",   {31'b0, err}, 32'd0);
    check_eq("rst_ireq",  {31'b0, imem_req}, 32'd0);
    check_eq("rst_dreq",  {31'b0, dmem_req}, 32'd0);
    check_eq("rst_clk",   clock_count, 32'd0);
    check_eq("rst_instr", instr_cnt, 32'd0);

    // T1: addi/addi/add/EOF, zero wait
    clear_prog();
    imem[0] = enc_i(32'd5, 5'd0, 3'b000, 5'd1, OPI);
    imem[1] = enc_i(32'hFFFF_FFFD, 5'd0, 3'b000, 5'd2, OPI);
    imem[2] = enc_r(7'b0000000, 5'd2, 5'd1, 3'b000, 5'd3);
    run_prog("t1");
    check_eq("t1_x1", dut.r_regs[1], 32'd5);
    check_eq("t1_x2", dut.r_regs[2], 32'hFFFF_FFFD);
    check_eq("t1_x3", dut.r_regs[3], 32'd2);
    check_eq("t1_done", {31'b0, done}, 32'd1);
    check_eq("t1_err", {31'b0, err}, 32'd0);
    check_eq("t1_instr", instr_cnt, 32'd3);
    check_eq("t1_clk", clock_count, 32'd13);
    repeat (5) @(negedge clk);
    check_eq("t1_clk_hold", clock_count, 32'd13);
    check_eq("t1_done_hold", {31'b0, done}, 32'd1);
    check_eq("t1_ireq_halt", {31'b0, imem_req}, 32'd0);

    // T2: sw then lw with 3 wait cycles on dmem
    clear_prog();
    imem[0] = enc_i(32'd5, 5'd0, 3'b000, 5'd1, OPI);
    imem[1] = enc_s(32'd8, 5'd1, 5'd0);
    imem[2] = enc_i(32'd8, 5'd0, 3'b010, 5'd4, 7'b0000011);
    d_wait  = 3;
    begin
      int base;
      base = n_acc;
      run_prog("t2");
      check_eq("t2_nacc", n_acc - base, 32'd2);
      check_eq("t2_st_addr", {19'b0, acc_addr[base]}, 32'd2);
      check_eq("t2_st_wdata", acc_wdata[base], 32'd5);
      check_eq("t2_st_we", {31'b0, acc_we[base]}, 32'd1);
      check_eq("t2_st_cyc", acc_cycles[base], 32'd4);
      check_eq("t2_ld_addr", {19'b0, acc_addr[base+1]}, 32'd2);
      check_eq("t2_ld_we", {31'b0, acc_we[base+1]}, 32'd0);
      check_eq("t2_ld_cyc", acc_cycles[base+1], 32'd4);
    end
    check_eq("t2_x4", dut.r_regs[4], 32'd5);
    check_eq("t2_instr", instr_cnt, 32'd3);
    check_eq("t2_clk", clock_count, 32'd20);
    d_wait = 0;

    // T3: blt taken, bge not taken, jal link
    clear_prog();
    imem[0] = enc_i(32'd5, 5'd0, 3'b000, 5'd1, OPI);
    imem[1] = enc_i(32'hFFFF_FFFD, 5'd0, 3'b000, 5'd2, OPI);
    imem[2] = enc_b(32'd8, 5'd1, 5'd2, 3'b100);
    imem[3] = enc_i(32'd1, 5'd0, 3'b000, 5'd8, OPI);
    imem[4] = enc_b(32'd8, 5'd1, 5'd2, 3'b101);
    imem[5] = enc_i(32'd1, 5'd0, 3'b000, 5'd9, OPI);
    imem[6] = enc_j(32'd12, 5'd5);
    imem[7] = enc_i(32'd1, 5'd0, 3'b000, 5'd10, OPI);
    imem[8] = enc_i(32'd1, 5'd0, 3'b000, 5'd10, OPI);
    run_prog("t3");
    check_eq("t3_x8_skipped", dut.r_regs[8], 32'd0);
    check_eq("t3_x9_bge_nt", dut.r_regs[9], 32'd1);
    check_eq("t3_x5_link", dut.r_regs[5], 32'd28);
    check_eq("t3_x10_skipped", dut.r_regs[10], 32'd0);
    check_eq("t3_instr", instr_cnt, 32'd6);
    check_eq("t3_clk", clock_count, 32'd23);

    // T4: mul
    clear_prog();
    imem[0] = enc_i(32'd5, 5'd0, 3'b000, 5'd1, OPI);
    imem[1] = enc_r(7'b0000001, 5'd1, 5'd1, 3'b000, 5'd6);
    run_prog("t4");
`ifdef RISCV_MUL_EN
    check_eq("t4_x6", dut.r_regs[6], 32'd25);
    check_eq("t4_done", {31'b0, done}, 32'd1);
    check_eq("t4_err", {31'b0, err}, 32'd0);
    check_eq("t4_instr", instr_cnt, 32'd2);
`else
    check_eq("t4_x6", dut.r_regs[6], 32'd0);
    check_eq("t4_done", {31'b0, done}, 32'd0);
    check_eq("t4_err", {31'b0, err}, 32'd1);
    check_eq("t4_instr", instr_cnt, 32'd1);
`endif

    // T5: x0 is hardwired
    clear_prog();
    imem[0] = enc_i(32'd7, 5'd0, 3'b000, 5'd0, OPI);
    imem[1] = enc_i(32'd9, 5'd0, 3'b000, 5'd7, OPI);
    imem[2] = enc_r(7'b0000000, 5'd0, 5'd0, 3'b000, 5'd7);
    run_prog("t5");
    check_eq("t5_x7", dut.r_regs[7], 32'd0);
    check_eq("t5_instr", instr_cnt, 32'd3);

    // T6: lui, auipc, jalr, slti, sub, beq
    clear_prog();
    imem[0] = enc_u(20'h12345, 5'd11, 7'b0110111);
    imem[1] = enc_u(20'h00001, 5'd12, 7'b0010111);
    imem[2] = enc_i(32'd20, 5'd0, 3'b000, 5'd13, OPI);
    imem[3] = enc_i(32'd1, 5'd13, 3'b000, 5'd14, 7'b1100111);
    imem[4] = enc_i(32'd1, 5'd0, 3'b000, 5'd15, OPI);
    imem[5] = enc_i(32'd21, 5'd13, 3'b010, 5'd16, OPI);
    imem[6] = enc_r(7'b0100000, 5'd13, 5'd0, 3'b000, 5'd17);
    imem[7] = enc_b(32'd8, 5'd0, 5'd0, 3'b000);
    imem[8] = enc_i(32'd2, 5'd0, 3'b000, 5'd15, OPI);
    run_prog("t6");
    check_eq("t6_lui", dut.r_regs[11], 32'h1234_5000);
    check_eq("t6_auipc", dut.r_regs[12], 32'h0000_1004);
    check_eq("t6_jalr_link", dut.r_regs[14], 32'd16);
    check_eq("t6_x15_skipped", dut.r_regs[15], 32'd0);
    check_eq("t6_slti", dut.r_regs[16], 32'd1);
    check_eq("t6_sub", dut.r_regs[17], 32'hFFFF_FFEC);
    check_eq("t6_instr", instr_cnt, 32'd7);
    check_eq("t6_done", {31'b0, done}, 32'd1);

    // T7: illegal opcode
    clear_prog();
    imem[0] = enc_i(32'd5, 5'd0, 3'b000, 5'd1, OPI);
    imem[1] = 32'h0000_0000;
    run_prog("t7");
    check_eq("t7_err", {31'b0, err}, 32'd1);
    check_eq("t7_done", {31'b0, done}, 32'd0);
    check_eq("t7_instr", instr_cnt, 32'd1);

    // T8: reset asserted during a MEM wait
    clear_prog();
    imem[0] = enc_i(32'd5, 5'd0, 3'b000, 5'd1, OPI);
    imem[1] = enc_s(32'd8, 5'd1, 5'd0);
    d_wait  = 50;
    start_core();
    begin
      int c;
      c = 0;
      while (c < 200 && !dmem_req) begin
        @(negedge clk);
        c++;
      end
      check_eq("t8_reached_mem", {31'b0, dmem_req}, 32'd1);
    end
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check_eq("t8_dreq_drop", {31'b0, dmem_req}, 32'd0);
    check_eq("t8_dwe_clr", {31'b0, dmem_we}, 32'd0);
    check_eq("t8_ireq", {31'b0, imem_req}, 32'd0);
    check_eq("t8_pc", dut.r_pc, 32'd0);
    check_eq("t8_clk", clock_count, 32'd0);
    check_eq("t8_instr", instr_cnt, 32'd0);
    d_wait = 0;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/riscv_multi_core.md
# riscv_multi_core

Parametrised successor to the team's fixed multicycle RV32 CPU. Executes a 32-bit RISC-V integer subset with a multicycle state machine and fetches and loads through external req/ack memory ports, so instruction and data memories may have any latency. Sits between the board top (clock, reset, LEDs) and the instruction and data RAM instances. It reports completion, error, cycle count and retired-instruction count.

## Interface
- IMEM_AW, 6: instruction memory word-address width.
- DMEM_AW, 13: data memory word-address width.
- RESET_PC, 0: byte address loaded into PC on reset.
- EOF_WORD, 32'hFFFF_FFFF: halt pseudo-instruction.

Ports:
- CLOCK_50 in 1: single clock, all logic on its rising edge.
- rst in 1: asynchronous, active-low reset.
- imem_req out 1: fetch request.
- imem_addr out IMEM_AW: word address, equal to PC[IMEM_AW+1:2].
- imem_ack in 1: fetch data valid this cycle.
- imem_rdata in 32: instruction word.
- dmem_req out 1: data access request.
- dmem_we out 1: 1 = store, 0 = load.
- dmem_addr out DMEM_AW: word address, equal to ALUOut[DMEM_AW+1:2].
- dmem_wdata out 32: store data (rs2).
- dmem_ack in 1: access complete; load data valid.
- dmem_rdata in 32: load data.
- done out 1: EOF retired; core halted.
- err out 1: illegal instruction; core halted.
- clock_count out 32: cycles since reset, excluding HALT.
- instr_cnt out 32: retired instructions.

## Operation
- Supported instructions: add, sub, [mul], addi, slti, lui, auipc, lw, sw, beq, bne, blt, bge, jal, jalr.
- Any other opcode/funct combination goes to HALT with err=1. x0 reads 0, and writes to it are discarded.
- States are IF, ID, EX, MEM, WB, HALT. Reset state is IF.
- **IF:** assert imem_req. On imem_ack, capture IR = imem_rdata and go to ID. PC is not yet incremented.
- **ID:**
  - If IR == EOF_WORD: done=1, go to HALT.
  - Otherwise read rs1/rs2, compute the immediate (I/S/B/U/J types, sign-extended), and set target = PC + imm. Go to EX.
- **EX:**
  - ALU result goes to ALUOut.
  - Branch: PC = taken ? target : PC+4, retire, go to IF.
  - lw/sw: ALUOut = rs1 + imm, go to MEM.
  - Others go to WB.
- **MEM:** hold dmem_req, dmem_we, dmem_addr and dmem_wdata stable until dmem_ack.
  - On ack, a load captures MDR = dmem_rdata and goes to WB.
  - A store retires and goes to IF.
- **WB:**
  - Write rd with ALUOut, MDR, or PC+4 (jal/jalr).
  - PC = jal ? target : jalr ? (rs1+imm)&~1 : PC+4.
  - Retire, go to IF.
- **HALT:** absorbing. Only reset exits.
- Retire increments instr_cnt by 1. Both counters wrap modulo 2^32.
- Arithmetic is 32-bit, modulo 2^32. blt/bge/slti are signed. mul keeps the low 32 bits.
- Low two address bits are ignored on both ports; no misalignment trap.

## Timing
- Reset asynchronously clears:
  - PC = RESET_PC, regs = 0, state = IF, both counters = 0.
  - done, err, imem_req, dmem_req, dmem_we = 0.
  - dmem_wdata, dmem_addr, imem_addr-source = 0.
- First imem_req is asserted in the first cycle after rst deasserts.
- Ack may arrive in the same cycle as req (zero wait). Each wait cycle adds one cycle of latency.
- Zero-wait latency per instruction:
  - branch: 3 cycles.
  - ALU, lui, auipc, jal, jalr, sw: 4 cycles.
  - lw: 5 cycles.
- A req stays high from state entry until the ack cycle inclusive, then drops the next cycle.
- Ack while req is low is ignored.
- Reset mid-transaction drops req immediately. The memories must abandon the access.
- done/err rise the cycle after ID/EX detection and hold until reset.

## Configuration
- RISCV_MUL_EN defined: mul (funct7 = 0000001, funct3 = 000) executes via the combinational multiplier in EX.
- RISCV_MUL_EN undefined: no multiplier is synthesised, and mul is illegal (err=1, HALT).

## Structure
- Shared package riscv_pkg:
  - opcode constants (R, I-load, I-imm, S, B, U, AUIPC, JAL, JALR).
  - funct3/funct7 codes.
  - state encoding typedef.
  - EOF default.
- One sub-module: riscv_alu.
  - Combinational: op select, a, b → result, plus lt/eq flags for branches.
  - Holds the RISCV_MUL_EN guard.
- Register file is inline in the core.

## Test plan
- Zero-wait memories, program `addi x1,x0,5; addi x2,x0,-3; add x3,x1,x2; EOF` → x3 = 2, done=1, instr_cnt = 3, clock_count = 13 (4+4+4+1).
- Program `sw x1,8(x0); lw x4,8(x0)` with dmem_ack delayed 3 cycles → dmem_addr = 2, wdata = 5, x4 = 5, req held 4 cycles each access.
- Program `blt x2,x1,+8` with x1=5, x2=-3 → PC skips one instruction; bge same operands not taken; jal x5,+12 → x5 = PC+4.
- Program `mul x6,x1,x1` → x6 = 25 with RISCV_MUL_EN; without it, err=1, done=0, instr_cnt unchanged.
- Assert rst low during MEM wait → dmem_req falls same cycle; after release, PC = RESET_PC and counters = 0.
- Program `addi x0,x0,7` then `add x7,x0,x0` → x7 = 0.
